// File: rtl/median_line_ctrl_pkg.sv
// rtl/median_line_ctrl_pkg.sv - shared state type, parameter defaults and h_size helper
package median_ctrl_pkg;

  localparam int CNT_W_DEF      = 12;
  localparam int WIN_DEF        = 5;
  localparam int LOCK_LINES_DEF = 2;
  localparam int MIN_PERIOD_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    LOCKED,
    RUN
  } state_t;

  // Delay-line length that makes a WIN-wide window span exactly one line.
  function automatic logic [31:0] h_size_of(input logic [31:0] period, input logic [31:0] win);
    return period - win;
  endfunction

endpackage

// File: rtl/median_line_ctrl_if.sv
// rtl/median_line_ctrl_if.sv - video timing inputs and line-config outputs of median_line_ctrl
interface median_line_ctrl_if
  import median_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             de_in;
  logic             h_sync_in;
  logic             v_sync_in;
  logic [CNT_W-1:0] h_size_out;
  logic             locked;
  logic             filter_en;
  logic             timing_err;

  modport master (
    output de_in, h_sync_in, v_sync_in,
    input  h_size_out, locked, filter_en, timing_err
  );

  modport slave (
    input  de_in, h_sync_in, v_sync_in,
    output h_size_out, locked, filter_en, timing_err
  );

endinterface

// File: rtl/median_line_ctrl_sync_edge_det.sv
// rtl/median_line_ctrl_sync_edge_det.sv - previous-value register and combinational rising-edge flag
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/median_line_ctrl.sv
// rtl/median_line_ctrl.sv - line period lock and filter gating for the 5x5 median window
// Optional MEDIAN_CTRL_VCHECK_EN: lines-per-frame check while running.
module median_line_ctrl
  import median_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN        = WIN_DEF,
  parameter int LOCK_LINES = LOCK_LINES_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input logic               clk,
  input logic               rst,
  median_line_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_PERIOD);
  localparam logic [2:0]       LOCK_C  = 3'(LOCK_LINES);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] h_size_q;
  logic [2:0]       match_q;
  logic             locked_q;
  logic             filter_en_q;
  logic             timing_err_q;

  logic             hs_rise;
  logic             vs_rise;
  logic [CNT_W-1:0] period;
  logic             active;
  logic             timeout;
  logic             period_ok;
  logic             match_hit;
  logic [2:0]       match_inc;
  logic             frame_bad;

  // Data enable is carried on the bus for the window block; timing here ignores it.
  wire unused_de = bus.de_in;

  sync_edge_det u_hs_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.h_sync_in),
    .rise_o (hs_rise)
  );

  sync_edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.v_sync_in),
    .rise_o (vs_rise)
  );

  assign period    = cnt_q;
  assign active    = (state_q == MEASURE) || (state_q == LOCKED) || (state_q == RUN);
  assign timeout   = active && !hs_rise && (cnt_q == CNT_MAX);
  assign period_ok = (period == h_size_q + WIN_C);
  assign match_hit = (period == prev_q) && (period >= MIN_C);
  assign match_inc = match_q + 3'd1;

`ifdef MEDIAN_CTRL_VCHECK_EN
  logic [CNT_W-1:0] line_cnt_q;
  logic [CNT_W-1:0] frame_lines_q;

  // A line starting on the vsync edge belongs to the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      if (vs_rise) begin
        line_cnt_q <= hs_rise ? ONE : '0;
      end else if (hs_rise && (line_cnt_q != CNT_MAX)) begin
        line_cnt_q <= line_cnt_q + ONE;
      end
      if ((state_q == LOCKED) && vs_rise) begin
        frame_lines_q <= line_cnt_q;
      end
    end
  end

  assign frame_bad = vs_rise && (line_cnt_q != frame_lines_q);
`else
  assign frame_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prev_q       <= '0;
      match_q      <= '0;
      h_size_q     <= '0;
      locked_q     <= 1'b0;
      filter_en_q  <= 1'b0;
      timing_err_q <= 1'b0;
    end else begin
      timing_err_q <= 1'b0;

      if ((state_q == IDLE) || ((state_q == ARM) && !hs_rise)) begin
        cnt_q <= '0;
      end else if (hs_rise) begin
        cnt_q <= ONE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + ONE;
      end

      if (timeout) begin
        state_q      <= IDLE;
        timing_err_q <= locked_q;
        locked_q     <= 1'b0;
        filter_en_q  <= 1'b0;
        match_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (vs_rise) state_q <= ARM;
          end
          ARM: begin
            if (hs_rise) begin
              prev_q  <= '0;
              match_q <= '0;
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (hs_rise) begin
              prev_q <= period;
              if (!match_hit) begin
                match_q <= '0;
              end else if (match_inc == LOCK_C) begin
                match_q  <= match_inc;
                h_size_q <= CNT_W'(h_size_of(32'(period), 32'(WIN)));
                locked_q <= 1'b1;
                state_q  <= LOCKED;
              end else begin
                match_q <= match_inc;
              end
            end
          end
          LOCKED, RUN: begin
            // Period check wins over a coincident vsync.
            if (hs_rise && !period_ok) begin
              locked_q     <= 1'b0;
              filter_en_q  <= 1'b0;
              timing_err_q <= 1'b1;
              match_q      <= '0;
              prev_q       <= period;
              state_q      <= MEASURE;
            end else if ((state_q == LOCKED) && vs_rise) begin
              filter_en_q <= 1'b1;
              state_q     <= RUN;
            end else if ((state_q == RUN) && frame_bad) begin
              locked_q     <= 1'b0;
              filter_en_q  <= 1'b0;
              timing_err_q <= 1'b1;
              match_q      <= '0;
              prev_q       <= h_size_q + WIN_C;
              state_q      <= MEASURE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.h_size_out = h_size_q;
  assign bus.locked     = locked_q;
  assign bus.filter_en  = filter_en_q;
  assign bus.timing_err = timing_err_q;

endmodule

// File: tb/tb_median_line_ctrl.sv
// tb/tb_median_line_ctrl.sv - directed and randomized check of median_line_ctrl against an event model
module tb_median_line_ctrl;

  localparam int CW     = 12;
  localparam int WIN_M  = 5;
  localparam int LOCK_M = 2;
  localparam int MINP_M = 8;
  localparam int CMAX   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  median_line_ctrl_if #(.CNT_W(CW)) bus ();

  median_line_ctrl #(
    .CNT_W      (CW),
    .WIN        (WIN_M),
    .LOCK_LINES (LOCK_M),
    .MIN_PERIOD (MINP_M)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;
  int err_seen = 0;

  typedef enum {M_IDLE, M_ARM, M_MEAS, M_LOCK, M_RUN} mst_t;
  mst_t m_st;
  int   m_h, cyc, last_rise, prev_per, run_len;
  bit   m_lock, m_fen, m_err;
  bit   h_last, v_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_h = 0; m_lock = 0; m_fen = 0; m_err = 0;
    last_rise = cyc; prev_per = 0; run_len = 0;
  endtask

  // One clock edge of the reference: acts only on sync events and elapsed time.
  task automatic model_step(input bit hs, input bit vs);
    int per;
    cyc++;
    m_err = 0;
    case (m_st)
      M_IDLE: if (vs) m_st = M_ARM;
      M_ARM: if (hs) begin
        last_rise = cyc; prev_per = 0; run_len = 0; m_st = M_MEAS;
      end
      default: begin
        if (!hs && (cyc - last_rise >= CMAX)) begin
          m_err = m_lock; m_lock = 0; m_fen = 0; run_len = 0; m_st = M_IDLE;
        end else if (hs) begin
          per = cyc - last_rise;
          last_rise = cyc;
          if (m_st == M_MEAS) begin
            if (per == prev_per && per >= MINP_M) run_len++;
            else run_len = 0;
            prev_per = per;
            if (run_len == LOCK_M) begin
              m_h = per - WIN_M; m_lock = 1; m_st = M_LOCK;
            end
          end else if (per != m_h + WIN_M) begin
            m_lock = 0; m_fen = 0; m_err = 1; run_len = 0; prev_per = per; m_st = M_MEAS;
          end else if (m_st == M_LOCK && vs) begin
            m_fen = 1; m_st = M_RUN;
          end
        end else if (m_st == M_LOCK && vs) begin
          m_fen = 1; m_st = M_RUN;
        end
      end
    endcase
  endtask

  task automatic tick();
    bit hs, vs;
    hs = bus.h_sync_in && !h_last;
    vs = bus.v_sync_in && !v_last;
    h_last = bus.h_sync_in;
    v_last = bus.v_sync_in;
    @(posedge clk);
    #1;
    model_step(hs, vs);
    if (bus.timing_err === 1'b1) err_seen++;
    chk("tick", {bus.h_size_out, bus.locked, bus.filter_en, bus.timing_err},
        {CW'(m_h), m_lock, m_fen, m_err});
  endtask

  task automatic line(input int p, input bit vs, input int vpos = 3);
    for (int c = 0; c < p; c++) begin
      bus.h_sync_in = (c < 2);
      bus.v_sync_in = vs && (c >= vpos) && (c < vpos + 2);
      bus.de_in     = (c >= 2);
      tick();
    end
  endtask

  task automatic lines(input int p, input int n);
    for (int i = 0; i < n; i++) line(p, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_async", {bus.h_size_out, bus.locked, bus.filter_en, bus.timing_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    h_last = 0; v_last = 0;
    model_reset();
  endtask

  initial begin
    bus.h_sync_in = 0; bus.v_sync_in = 0; bus.de_in = 0;
    cyc = 0; h_last = 0; v_last = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {bus.h_size_out, bus.locked, bus.filter_en, bus.timing_err}, 32'd0);
    rst = 1'b0;

    // Period 83: lock on the 4th hsync after arm, filter waits for next vsync.
    line(83, 1'b1);
    lines(83, 3);
    chk("p83_not_yet", bus.locked, 1'b0);
    line(83, 1'b0);
    chk("p83_locked", bus.locked, 1'b1);
    chk("p83_hsize", bus.h_size_out, 32'd78);
    chk("p83_fen_wait", bus.filter_en, 1'b0);
    line(83, 1'b1);
    chk("p83_fen_on", bus.filter_en, 1'b1);

    // 1650 then 1600.
    err_seen = 0;
    lines(1650, 4);
    line(1650, 1'b1);
    chk("p1650_locked", bus.locked, 1'b1);
    chk("p1650_hsize", bus.h_size_out, 32'd1645);
    chk("p1650_fen", bus.filter_en, 1'b1);
    chk("p1650_err_cnt", err_seen, 32'd1);
    err_seen = 0;
    lines(1600, 2);
    chk("p1600_unlock", bus.locked, 1'b0);
    chk("p1600_fen_off", bus.filter_en, 1'b0);
    chk("p1600_hsize_hold", bus.h_size_out, 32'd1645);
    chk("p1600_err_once", err_seen, 32'd1);
    lines(1600, 2);
    chk("p1600_relock", bus.locked, 1'b1);
    chk("p1600_hsize", bus.h_size_out, 32'd1595);

    // Reset mid-run, then reacquire only after vsync.
    line(1600, 1'b1);
    chk("run_before_rst", bus.filter_en, 1'b1);
    do_reset();
    lines(40, 6);
    chk("no_vs_no_lock", bus.locked, 1'b0);
    line(40, 1'b1);
    lines(40, 3);
    chk("p40_not_yet", bus.locked, 1'b0);
    line(40, 1'b0);
    chk("p40_locked", bus.locked, 1'b1);
    chk("p40_hsize", bus.h_size_out, 32'd35);

    // Period below minimum never locks.
    do_reset();
    line(5, 1'b1);
    lines(5, 12);
    chk("p5_no_lock", bus.locked, 1'b0);
    chk("p5_hsize", bus.h_size_out, 32'd0);

    // Timeout while running.
    lines(60, 4);
    chk("p60_locked", bus.locked, 1'b1);
    line(60, 1'b1);
    chk("p60_run", bus.filter_en, 1'b1);
    err_seen = 0;
    bus.h_sync_in = 0; bus.v_sync_in = 0;
    repeat (4200) tick();
    chk("to_unlock", bus.locked, 1'b0);
    chk("to_fen", bus.filter_en, 1'b0);
    chk("to_err_once", err_seen, 32'd1);
    lines(60, 5);
    chk("to_idle", bus.locked, 1'b0);

    // Randomized timing, including vsync coincident with hsync.
    for (int it = 0; it < 40; it++) begin
      int p, reps;
      p = int'($urandom_range(6, 150));
      reps = int'($urandom_range(1, 6));
      for (int r = 0; r < reps; r++) begin
        line(p, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0) ? 0 : 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
